// File: rtl/uart_rx.sv
// 8N1 UART receiver with run-time prescale and a valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  meta_q, rxs_q;
    logic [15:0]           p_q, p_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           p_in;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  ovr_q, ovr_d;
    logic                  ferr_q, ferr_d;
    logic                  deliver;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  perr_q, perr_d;
`endif

    assign p_in = (prescale < 16'd4) ? 16'd4 : prescale;

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q & ~m_axis_tready;
        ovr_d    = 1'b0;
        ferr_d   = 1'b0;
        deliver  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    p_d     = p_in;
                    cnt_d   = (p_in >> 1) - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxs_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = p_q - 16'd1;
                    idx_d   = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    // LSB arrives first and ends up at bit 0 after the last shift
                    sh_d  = {rxs_q, sh_q[DATA_WIDTH-1:1]};
                    cnt_d = p_q - 16'd1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    par_d   = rxs_q;
                    cnt_d   = p_q - 16'd1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    // leave mid-stop so a back-to-back start edge is caught
                    state_d = IDLE;
                    if (!rxs_q) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{sh_q, par_q}) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (deliver) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = sh_q;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b1;
            rxs_q    <= 1'b1;
            state_q  <= IDLE;
            p_q      <= 16'd4;
            cnt_q    <= 16'd0;
            idx_q    <= 4'd0;
            sh_q     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            meta_q   <= rxd;
            rxs_q    <= meta_q;
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != IDLE);
    assign overrun_error = ovr_q;
    assign frame_error   = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; serial frames are built from
// the bit-level frame format and received words are compared to a queue.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        tready = 1'b1;
    logic [15:0] prescale = 16'd16;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        busy;
    logic        ovr;
    logic        ferr;
`ifdef UART_RX_PARITY_EN
    logic        perr;
    logic        par_inv = 1'b0;
    int          n_perr = 0;
`endif

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy          (busy),
        .overrun_error (ovr),
`ifdef UART_RX_PARITY_EN
        .parity_error  (perr),
`endif
        .frame_error   (ferr)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         n_ovr = 0;
    int         n_ferr = 0;
    int         n_rise = 0;
    logic       tv_prev = 1'b0;

    always @(posedge clk) begin
        if (tvalid && tready) got.push_back(tdata);
        n_ovr   <= n_ovr + int'(ovr);
        n_ferr  <= n_ferr + int'(ferr);
`ifdef UART_RX_PARITY_EN
        n_perr  <= n_perr + int'(perr);
`endif
        tv_prev <= tvalid;
        if (tvalid && !tv_prev) n_rise <= n_rise + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one complete frame with bit period bp, followed by two idle bit times
    task automatic send(input logic [7:0] d, input logic stop, input int bp);
        rxd = 1'b0;
        cycles(bp);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cycles(bp);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_inv;
        cycles(bp);
`endif
        rxd = stop;
        cycles(bp);
        rxd = 1'b1;
        cycles(2 * bp);
    endtask

    initial begin
        int         o0, f0, r0, pr, bp;
        logic [7:0] d;
        logic       bad;

        cycles(2);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_ferr", ferr, 0);
        rst = 1'b0;
        cycles(4);

        // nominal
        got.delete();
        o0 = n_ovr; f0 = n_ferr; r0 = n_rise;
        send(8'hA5, 1'b1, 16);
        check("nom_count", got.size(), 1);
        check("nom_data", got[0], 8'hA5);
        check("nom_rise", n_rise - r0, 1);
        check("nom_errs", (n_ovr - o0) + (n_ferr - f0), 0);
        check("nom_busy", busy, 0);
        check("nom_tvalid", tvalid, 0);

        // back-pressure and overrun
        got.delete();
        o0 = n_ovr;
        tready = 1'b0;
        send(8'h3C, 1'b1, 16);
        send(8'h81, 1'b1, 16);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_tvalid", tvalid, 1);
        check("ovr_tdata", tdata, 8'h3C);
        check("ovr_none_taken", got.size(), 0);
        tready = 1'b1;
        cycles(3);
        check("ovr_drain_tvalid", tvalid, 0);
        check("ovr_drain_count", got.size(), 1);
        check("ovr_drain_data", got[0], 8'h3C);

        // framing error then recovery
        got.delete();
        f0 = n_ferr; o0 = n_ovr;
        send(8'h55, 1'b0, 16);
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_tvalid", tvalid, 0);
        check("ferr_count", got.size(), 0);
        send(8'h12, 1'b1, 16);
        check("ferr_next_count", got.size(), 1);
        check("ferr_next_data", got[0], 8'h12);
        check("ferr_no_more", (n_ferr - f0) + (n_ovr - o0), 1);

        // short glitch on the line
        got.delete();
        r0 = n_rise; f0 = n_ferr;
        rxd = 1'b0;
        cycles(3);
        rxd = 1'b1;
        cycles(3);
        check("glitch_busy_mid", busy, 1);
        cycles(16);
        check("glitch_busy_after", busy, 0);
        check("glitch_no_word", n_rise - r0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // reset in the middle of a frame, with a word still pending
        got.delete();
        tready = 1'b0;
        d = 8'($urandom);
        send(d, 1'b1, 16);
        check("pend_tvalid", tvalid, 1);
        check("pend_tdata", tdata, d);
        rxd = 1'b0;
        cycles(16);
        rxd = 1'b1;
        cycles(48);
        check("abort_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_tvalid", tvalid, 0);
        check("abort_tdata", tdata, 0);
        check("abort_busy", busy, 0);
        cycles(2);
        rst = 1'b0;
        cycles(120);
        tready = 1'b1;
        check("abort_no_output", got.size(), 0);
        send(8'h0F, 1'b1, 16);
        check("abort_next_count", got.size(), 1);
        check("abort_next_data", got[0], 8'h0F);

        // prescale change mid-frame is ignored
        got.delete();
        prescale = 16'd868;
        cycles(2);
        fork
            send(8'h7E, 1'b1, 868);
            begin
                cycles(3000);
                prescale = 16'd16;
            end
        join
        check("slow_count", got.size(), 1);
        check("slow_data", got[0], 8'h7E);
        send(8'hC3, 1'b1, 16);
        check("fast_count", got.size(), 2);
        check("fast_data", got[1], 8'hC3);

        // randomized frames, bit periods and stop bits, incl. clamp below 4
        got.delete();
        exp_q.delete();
        f0 = n_ferr; o0 = n_ovr;
        r0 = 0;
        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            pr  = int'($urandom_range(1, 30));
            bp  = (pr < 4) ? 4 : pr;
            bad = ($urandom_range(0, 4) == 0);
            prescale = 16'(pr);
            cycles(1);
            send(d, !bad, bp);
            if (bad) r0++;
            else exp_q.push_back(d);
        end
        check("rand_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_data%0d", i), got[i], exp_q[i]);
        end
        check("rand_ferr", n_ferr - f0, r0);
        check("rand_ovr", n_ovr - o0, 0);

`ifdef UART_RX_PARITY_EN
        got.delete();
        prescale = 16'd16;
        f0 = n_perr;
        par_inv = 1'b0;
        send(8'hA5, 1'b1, 16);
        check("par_ok_count", got.size(), 1);
        check("par_ok_data", got[0], 8'hA5);
        check("par_ok_perr", n_perr - f0, 0);
        par_inv = 1'b1;
        send(8'hA5, 1'b1, 16);
        par_inv = 1'b0;
        check("par_bad_perr", n_perr - f0, 1);
        check("par_bad_count", got.size(), 1);
        check("par_bad_tvalid", tvalid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
